axi4_lite_reg_bank: RTL and testbench

- AXI4-Lite responder (slave endpoint) that terminates transactions with a bank of REG_COUNT 32-bit read/write registers.
- This is the far end of an AXI-Lite path: local master → remapper/bridge → this block.
- Register contents are exported as a flat bus to user logic. A one-cycle write pulse per register notifies user logic of each update.
- Out-of-range accesses are answered with DECERR rather than hanging the bus.

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_addr_decode.sv | 27 ++
 rtl/axi4_lite_reg_bank.sv | 219 +++++++++++++++++++++
 tb/tb_axi4_lite_reg_bank.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types, sizing helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  // Width of a register index; a single-register bank still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder: byte address -> register index and range flag.
// Addresses below BASE_ADDR wrap to huge offsets and so decode as out of range.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          REG_COUNT      = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          IDX_W          = idx_width(REG_COUNT)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  output logic [IDX_W-1:0]          o_index,
  output logic                      o_in_range
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BASE  = AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH:0]   LIMIT = (AXI_ADDR_WIDTH+1)'(4 * REG_COUNT);

  logic [AXI_ADDR_WIDTH-1:0] w_offset;
  logic                      w_unused_lsbs;

  assign w_offset      = i_addr - BASE;
  assign o_in_range    = ({1'b0, w_offset} < LIMIT);
  assign o_index       = w_offset[IDX_W+1:2];
  assign w_unused_lsbs = ^w_offset[1:0];

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite responder terminating accesses on a bank of REG_COUNT registers.
// Register contents are exported flat on reg_out; wr_pulse flags each update.
// Optional macro AXI_REG_BANK_WSTRB_EN enables per-byte write strobes;
// without it every in-range write replaces the full word.
module axi4_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          REG_COUNT      = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic [AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  input  logic [2:0]                          S_AXI_ARPROT,
  output logic [AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [AXI_DATA_WIDTH*REG_COUNT-1:0] reg_out,
  output logic [REG_COUNT-1:0]                wr_pulse
);

  localparam int IDX_W  = idx_width(REG_COUNT);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  wstate_t                     r_wstate;
  logic                        r_awready;
  logic                        r_wready;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;
  logic [IDX_W-1:0]            r_aw_index;
  logic                        r_aw_in_range;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]           r_wstrb;

  rstate_t                     r_rstate;
  logic                        r_arready;
  logic                        r_rvalid;
  logic [1:0]                  r_rresp;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;

  logic [AXI_DATA_WIDTH-1:0]   r_regs [REG_COUNT];
  logic [REG_COUNT-1:0]        r_wr_pulse;

  logic [IDX_W-1:0]            w_aw_index;
  logic                        w_aw_in_range;
  logic [IDX_W-1:0]            w_ar_index;
  logic                        w_ar_in_range;
  logic                        w_commit;
  logic [AXI_DATA_WIDTH-1:0]   w_merged;
  logic                        w_unused_ok;

  axi_lite_addr_decode #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .REG_COUNT      (REG_COUNT),
    .BASE_ADDR      (BASE_ADDR),
    .IDX_W          (IDX_W)
  ) u_aw_decode (
    .i_addr     (S_AXI_AWADDR),
    .o_index    (w_aw_index),
    .o_in_range (w_aw_in_range)
  );

  axi_lite_addr_decode #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .REG_COUNT      (REG_COUNT),
    .BASE_ADDR      (BASE_ADDR),
    .IDX_W          (IDX_W)
  ) u_ar_decode (
    .i_addr     (S_AXI_ARADDR),
    .o_index    (w_ar_index),
    .o_in_range (w_ar_in_range)
  );

  // Both address and data are held once their READY has dropped in W_IDLE.
  assign w_commit = (r_wstate == W_IDLE) && !r_awready && !r_wready;

  // Word to store on commit: strobed byte merge or full replacement.
  always_comb begin
    w_merged = r_wdata;
`ifdef AXI_REG_BANK_WSTRB_EN
    w_merged = r_regs[r_aw_index];
    for (int b = 0; b < STRB_W; b++) begin
      if (r_wstrb[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
`endif
  end

  // Write channel FSM: accept AW and W independently, commit, then hold B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate      <= W_IDLE;
      r_awready     <= 1'b1;
      r_wready      <= 1'b1;
      r_bvalid      <= 1'b0;
      r_bresp       <= RESP_OKAY;
      r_aw_index    <= '0;
      r_aw_in_range <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (S_AXI_AWVALID && r_awready) begin
            r_awready     <= 1'b0;
            r_aw_index    <= w_aw_index;
            r_aw_in_range <= w_aw_in_range;
          end
          if (S_AXI_WVALID && r_wready) begin
            r_wready <= 1'b0;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
          end
          if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_in_range ? RESP_OKAY : RESP_DECERR;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Register storage and the one-cycle update pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && r_aw_in_range) begin
        r_regs[r_aw_index]     <= w_merged;
        r_wr_pulse[r_aw_index] <= 1'b1;
      end
    end
  end

  // Read channel FSM: sample the register on the AR handshake, hold R.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rstate  <= R_RESP;
            if (w_ar_in_range) begin
              r_rdata <= r_regs[w_ar_index];
              r_rresp <= RESP_OKAY;
            end else begin
              r_rdata <= '0;
              r_rresp <= RESP_DECERR;
            end
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_out
    assign reg_out[AXI_DATA_WIDTH*g +: AXI_DATA_WIDTH] = r_regs[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse      = r_wr_pulse;

  // Protection bits carry no meaning here; strobes only matter when enabled.
`ifdef AXI_REG_BANK_WSTRB_EN
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, RESP_SLVERR};
`else
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, RESP_SLVERR, r_wstrb};
`endif

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Testbench for axi4_lite_reg_bank: directed scenarios plus randomized traffic,
// checked by a scoreboard against a word-array model of the register bank.
module tb_axi4_lite_reg_bank;
  import axi_lite_pkg::*;

  localparam int          REG_COUNT = 16;
  localparam logic [31:0] BASE      = 32'h0000_1000;
`ifdef AXI_REG_BANK_WSTRB_EN
  localparam logic [31:0] EXP_STRB_WORD = 32'h00FF_00FF;
`else
  localparam logic [31:0] EXP_STRB_WORD = 32'hFFFF_FFFF;
`endif

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic [31:0]               S_AXI_AWADDR = '0;
  logic                      S_AXI_AWVALID = 1'b0;
  logic                      S_AXI_AWREADY;
  logic [2:0]                S_AXI_AWPROT = '0;
  logic [31:0]               S_AXI_WDATA = '0;
  logic [3:0]                S_AXI_WSTRB = '0;
  logic                      S_AXI_WVALID = 1'b0;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY = 1'b0;
  logic [31:0]               S_AXI_ARADDR = '0;
  logic                      S_AXI_ARVALID = 1'b0;
  logic                      S_AXI_ARREADY;
  logic [2:0]                S_AXI_ARPROT = '0;
  logic [31:0]               S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY = 1'b0;
  logic [32*REG_COUNT-1:0]   reg_out;
  logic [REG_COUNT-1:0]      wr_pulse;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0]  bq [$];
  rexp_t       rq [$];
  int          pq [$];
  logic [31:0] model [REG_COUNT];
  int          compared = 0;
  int          mismatched = 0;

  axi4_lite_reg_bank #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (32),
    .REG_COUNT      (REG_COUNT),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: no handshake within 50 cycles", name);
  endtask

  // Reference decode straight from the address map rules.
  function automatic logic inRange(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * REG_COUNT);
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] strb);
    logic [31:0] res;
    res = data;
`ifdef AXI_REG_BANK_WSTRB_EN
    res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
`endif
    return res;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0: return S_AXI_AWREADY;
      1: return S_AXI_WREADY;
      2: return S_AXI_ARREADY;
      3: return S_AXI_BVALID;
      default: return S_AXI_RVALID;
    endcase
  endfunction

  // Waits on negedges for the selected signal, bounded to 50 cycles.
  task automatic waitFor(input int which, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!sig(which) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!sig(which)) timeoutFail(name);
  endtask

  task automatic checkRegs();
    for (int i = 0; i < REG_COUNT; i++)
      checkOutput($sformatf("reg_out[%0d]", i), 64'(reg_out[32*i +: 32]), 64'(model[i]));
  endtask

  // Full write transaction; expectations are queued before any pin moves.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDelay, input int wDelay, input int bDelay);
    logic [1:0] expResp;
    int idx;
    if (inRange(addr)) begin
      idx = idxOf(addr);
      model[idx] = mergeWord(model[idx], data, strb);
      expResp = RESP_OKAY;
      pq.push_back(idx);
    end else begin
      expResp = RESP_DECERR;
    end
    bq.push_back(expResp);
    fork
      begin
        if (awDelay > 0) begin repeat (awDelay) @(posedge clk); #1; end
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        waitFor(0, "aw handshake");
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
      end
      begin
        if (wDelay > 0) begin repeat (wDelay) @(posedge clk); #1; end
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        waitFor(1, "w handshake");
        @(posedge clk); #1;
        S_AXI_WVALID = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("bvalid before commit", 64'(S_AXI_BVALID), 64'(0));
    @(negedge clk);
    checkOutput("bvalid latency", 64'(S_AXI_BVALID), 64'(1));
    for (int i = 0; i < bDelay; i++) begin
      @(negedge clk);
      checkOutput("bvalid hold", 64'(S_AXI_BVALID), 64'(1));
      checkOutput("bresp hold", 64'(S_AXI_BRESP), 64'(expResp));
      checkOutput("awready while busy", 64'(S_AXI_AWREADY), 64'(0));
    end
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b1;
    waitFor(3, "b handshake");
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge clk);
    checkOutput("awready after b", 64'(S_AXI_AWREADY), 64'(1));
    checkOutput("wready after b", 64'(S_AXI_WREADY), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic doReadExp(input logic [31:0] addr, input logic [31:0] expData,
                           input logic [1:0] expResp, input int rDelay);
    rexp_t e;
    e.data = expData;
    e.resp = expResp;
    rq.push_back(e);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    waitFor(2, "ar handshake");
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    checkOutput("rvalid latency", 64'(S_AXI_RVALID), 64'(1));
    for (int i = 0; i < rDelay; i++) begin
      @(negedge clk);
      checkOutput("rdata hold", 64'(S_AXI_RDATA), 64'(expData));
    end
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b1;
    waitFor(4, "r handshake");
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge clk);
    checkOutput("arready after r", 64'(S_AXI_ARREADY), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic doRead(input logic [31:0] addr, input int rDelay);
    if (inRange(addr)) doReadExp(addr, model[idxOf(addr)], RESP_OKAY, rDelay);
    else               doReadExp(addr, 32'h0, RESP_DECERR, rDelay);
  endtask

  // Randomized mix of reads and writes around and outside the register window.
  task automatic applyStimulus(input int n);
    logic [31:0] addr;
    int off;
    for (int k = 0; k < n; k++) begin
      off  = int'($urandom_range(0, 4*REG_COUNT + 16)) - 8;
      addr = BASE + 32'(off);
      if ($urandom_range(0, 1) == 1)
        doWrite(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        doRead(addr, int'($urandom_range(0, 2)));
      if (k % 8 == 7) checkRegs();
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever a response or pulse is presented.
  always @(negedge clk) begin
    if (resetn) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) timeoutFail("unexpected b response");
        else checkOutput("bresp", 64'(S_AXI_BRESP), 64'(bq.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) timeoutFail("unexpected r response");
        else begin
          rexp_t e;
          e = rq.pop_front();
          checkOutput("rdata", 64'(S_AXI_RDATA), 64'(e.data));
          checkOutput("rresp", 64'(S_AXI_RRESP), 64'(e.resp));
        end
      end
      if (wr_pulse != '0) begin
        if (pq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL wr_pulse: got 0x%0h, expected no pulse", wr_pulse);
        end else begin
          checkOutput("wr_pulse", 64'(wr_pulse), 64'(1) << pq.pop_front());
        end
      end
    end
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset awready", 64'(S_AXI_AWREADY), 64'(1));
    checkOutput("reset wready", 64'(S_AXI_WREADY), 64'(1));
    checkOutput("reset arready", 64'(S_AXI_ARREADY), 64'(1));
    checkOutput("reset bvalid", 64'(S_AXI_BVALID), 64'(0));
    checkOutput("reset rvalid", 64'(S_AXI_RVALID), 64'(0));
    checkOutput("reset rdata", 64'(S_AXI_RDATA), 64'(0));
    checkOutput("reset wr_pulse", 64'(wr_pulse), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;
    checkRegs();

    $display("[TB] same-cycle AW/W write then readback");
    doWrite(BASE + 32'h8, 32'h1234_5678, 4'hF, 0, 0, 0);
    checkOutput("reg2 word", 64'(reg_out[95:64]), 64'(32'h1234_5678));
    doRead(BASE + 32'h8, 0);

    $display("[TB] W leads AW by 3 cycles, BREADY held off");
    doWrite(BASE + 32'h14, 32'hCAFE_F00D, 4'hF, 3, 0, 5);
    checkRegs();

    $display("[TB] out-of-range accesses");
    doWrite(BASE + 32'(4*REG_COUNT), 32'hDEAD_BEEF, 4'hF, 0, 1, 1);
    doRead(BASE + 32'(4*REG_COUNT), 1);
    doRead(BASE - 32'd4, 0);
    checkRegs();

    $display("[TB] write commit on the same edge as AR handshake");
    doWrite(BASE, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    fork
      doWrite(BASE, 32'h5555_5555, 4'hF, 0, 0, 0);
      begin
        @(posedge clk); #1;
        doReadExp(BASE, 32'hAAAA_AAAA, RESP_OKAY, 2);
      end
    join
    doRead(BASE, 0);

    $display("[TB] byte strobes");
    doWrite(BASE + 32'h4, 32'h0, 4'hF, 0, 0, 0);
    doWrite(BASE + 32'h4, 32'hFFFF_FFFF, 4'b0101, 1, 0, 0);
    checkOutput("strobed reg1", 64'(reg_out[63:32]), 64'(EXP_STRB_WORD));

    $display("[TB] randomized traffic");
    applyStimulus(60);
    checkRegs();

    $display("[TB] reset with both responses pending");
    S_AXI_AWADDR  = BASE + 32'hC;
    S_AXI_WDATA   = 32'h0BAD_F00D;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = BASE + 32'hC;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    model[3] = mergeWord(model[3], 32'h0BAD_F00D, 4'hF);
    pq.push_back(3);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("pending bvalid", 64'(S_AXI_BVALID), 64'(1));
    checkOutput("pending rvalid", 64'(S_AXI_RVALID), 64'(1));
    #1;
    resetn = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
    #1;
    checkOutput("async bvalid drop", 64'(S_AXI_BVALID), 64'(0));
    checkOutput("async rvalid drop", 64'(S_AXI_RVALID), 64'(0));
    checkOutput("async wr_pulse", 64'(wr_pulse), 64'(0));
    checkRegs();
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    checkOutput("post reset awready", 64'(S_AXI_AWREADY), 64'(1));
    checkOutput("post reset wready", 64'(S_AXI_WREADY), 64'(1));
    checkOutput("post reset arready", 64'(S_AXI_ARREADY), 64'(1));
    for (int i = 0; i < REG_COUNT; i++) doRead(BASE + 32'(4*i), 0);

    checkOutput("b queue drained", 64'(bq.size()), 64'(0));
    checkOutput("r queue drained", 64'(rq.size()), 64'(0));
    checkOutput("pulse queue drained", 64'(pq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
